lcd_window_ctrl: RTL and testbench

//   Parametrised image-window display controller: loads an IMG_W x IMG_H frame into internal storage, then streams a
//   WIN x WIN window to the LCD driver after every command. Supports fit (subsampled) and zoom-in views, clamped

---
 rtl/lcd_ctrl_pkg.sv | 29 ++
 rtl/lcd_addr_map.sv | 51 +++++
 rtl/lcd_window_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_lcd_window_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_ctrl_pkg.sv
// rtl/lcd_ctrl_pkg.sv - command codes, FSM states and shared types for lcd_window_ctrl
package lcd_ctrl_pkg;

  localparam logic [3:0] CMD_LOAD    = 4'd0;
  localparam logic [3:0] CMD_ROT_L   = 4'd1;
  localparam logic [3:0] CMD_ROT_R   = 4'd2;
  localparam logic [3:0] CMD_ZOOM_IN = 4'd3;
  localparam logic [3:0] CMD_FIT     = 4'd4;
  localparam logic [3:0] CMD_SHIFT_R = 4'd5;
  localparam logic [3:0] CMD_SHIFT_L = 4'd6;
  localparam logic [3:0] CMD_SHIFT_U = 4'd7;
  localparam logic [3:0] CMD_SHIFT_D = 4'd8;
  localparam logic [3:0] CMD_MIRROR  = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EXEC,
    ST_OUT
  } state_t;

  typedef enum logic {
    MODE_FIT,
    MODE_ZOOM
  } mode_t;

  typedef logic [1:0] orient_t;

endpackage

// File: rtl/lcd_addr_map.sv
// rtl/lcd_addr_map.sv - display (r,c) to frame storage address mapper
module lcd_addr_map
  import lcd_ctrl_pkg::*;
#(
  parameter int IMG_W  = 12,
  parameter int WIN    = 4,
  parameter int FIT_SX = 3,
  parameter int FIT_OX = 1,
  parameter int FIT_SY = 2,
  parameter int FIT_OY = 1,
  parameter int AW     = 7,
  parameter int CW     = 2
) (
  input  logic [CW-1:0] r,
  input  logic [CW-1:0] c,
  input  orient_t       orient,
  input  logic          mirror,
  input  mode_t         mode,
  input  logic [AW-1:0] x,
  input  logic [AW-1:0] y,
  output logic [AW-1:0] addr
);

  logic [CW-1:0] cm;
  logic [CW-1:0] wi;
  logic [CW-1:0] wj;
  logic [AW-1:0] row;
  logic [AW-1:0] col;

  // Mirror the display column, rotate into window coords, then pick the source pixel
  always_comb begin
    cm = mirror ? (CW'(WIN - 1) - c) : c;
    wi = r;
    wj = cm;
    case (orient)
      2'd1: begin wi = CW'(WIN - 1) - cm; wj = r;                  end
      2'd2: begin wi = CW'(WIN - 1) - r;  wj = CW'(WIN - 1) - cm;  end
      2'd3: begin wi = cm;                wj = CW'(WIN - 1) - r;   end
      default: begin wi = r;              wj = cm;                 end
    endcase
    if (mode == MODE_ZOOM) begin
      row = y + AW'(wi);
      col = x + AW'(wj);
    end else begin
      row = AW'(FIT_OY) + AW'(FIT_SY) * AW'(wi);
      col = AW'(FIT_OX) + AW'(FIT_SX) * AW'(wj);
    end
    addr = row * AW'(IMG_W) + col;
  end

endmodule

// File: rtl/lcd_window_ctrl.sv
// rtl/lcd_window_ctrl.sv - window display controller top; LCD_WIN_MIRROR_EN enables cmd 9 mirror
module lcd_window_ctrl
  import lcd_ctrl_pkg::*;
#(
  parameter int DW     = 8,
  parameter int IMG_W  = 12,
  parameter int IMG_H  = 9,
  parameter int WIN    = 4,
  parameter int FIT_SX = 3,
  parameter int FIT_OX = 1,
  parameter int FIT_SY = 2,
  parameter int FIT_OY = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] datain,
  input  logic [3:0]    cmd,
  input  logic          cmd_valid,
  output logic [DW-1:0] dataout,
  output logic          output_valid,
  output logic          busy
);

  localparam int NPIX  = IMG_W * IMG_H;
  localparam int NOUT  = WIN * WIN;
  localparam int AW    = $clog2(NPIX);
  localparam int CW    = $clog2(WIN);
  localparam int X_MAX = IMG_W - WIN;
  localparam int Y_MAX = IMG_H - WIN;
  localparam int X_C   = (IMG_W - WIN) / 2;
  localparam int Y_C   = (IMG_H - WIN + 1) / 2;

`ifdef LCD_WIN_MIRROR_EN
  localparam logic [3:0] CMD_MAX = CMD_MIRROR;
`else
  localparam logic [3:0] CMD_MAX = CMD_SHIFT_D;
`endif

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [3:0]    cmd_q, cmd_d;
  mode_t         mode_q, mode_d;
  orient_t       orient_q, orient_d;
  logic          mirror_q, mirror_d;
  logic [AW-1:0] x_q, x_d;
  logic [AW-1:0] y_q, y_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic [DW-1:0] mem_q [NPIX];
  logic          mem_we;
  logic [AW-1:0] pix_addr;
  logic [1:0]    ddir;
  logic [1:0]    wdir;

  lcd_addr_map #(
    .IMG_W (IMG_W),  .WIN   (WIN),
    .FIT_SX(FIT_SX), .FIT_OX(FIT_OX),
    .FIT_SY(FIT_SY), .FIT_OY(FIT_OY),
    .AW    (AW),     .CW    (CW)
  ) u_map (
    .r     (cnt_q[2*CW-1:CW]),
    .c     (cnt_q[CW-1:0]),
    .orient(orient_q),
    .mirror(mirror_q),
    .mode  (mode_q),
    .x     (x_q),
    .y     (y_q),
    .addr  (pix_addr)
  );

  // Next-state, view-state update and output staging
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cmd_d    = cmd_q;
    mode_d   = mode_q;
    orient_d = orient_q;
    mirror_d = mirror_q;
    x_d      = x_q;
    y_d      = y_q;
    dout_d   = dout_q;
    valid_d  = 1'b0;
    mem_we   = 1'b0;
    ddir     = 2'd0;
    wdir     = 2'd0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && (cmd <= CMD_MAX)) begin
          cmd_d   = cmd;
          cnt_d   = '0;
          state_d = (cmd == CMD_LOAD) ? ST_LOAD : ST_EXEC;
        end
      end
      ST_LOAD: begin
        mem_we = 1'b1;
        cnt_d  = cnt_q + AW'(1);
        if (cnt_q == AW'(NPIX - 1)) begin
          cnt_d    = '0;
          state_d  = ST_OUT;
          mode_d   = MODE_FIT;
          orient_d = 2'd0;
          mirror_d = 1'b0;
        end
      end
      ST_EXEC: begin
        case (cmd_q)
          CMD_ROT_L:   orient_d = orient_q - 2'd1;
          CMD_ROT_R:   orient_d = orient_q + 2'd1;
          CMD_ZOOM_IN: begin
            mode_d = MODE_ZOOM;
            x_d    = AW'(X_C);
            y_d    = AW'(Y_C);
          end
          CMD_FIT:     mode_d = MODE_FIT;
          CMD_SHIFT_R, CMD_SHIFT_L, CMD_SHIFT_U, CMD_SHIFT_D: begin
            // Directions in clockwise order: right, down, left, up
            case (cmd_q)
              CMD_SHIFT_R: ddir = 2'd0;
              CMD_SHIFT_D: ddir = 2'd1;
              CMD_SHIFT_L: ddir = 2'd2;
              default:     ddir = 2'd3;
            endcase
            if (mirror_q && !ddir[0]) ddir = ddir ^ 2'd2;
            // A clockwise display rotation turns display moves anticlockwise on the frame
            wdir = ddir - orient_q;
            if (mode_q == MODE_ZOOM) begin
              case (wdir)
                2'd0:    if (x_q < AW'(X_MAX)) x_d = x_q + AW'(1);
                2'd1:    if (y_q < AW'(Y_MAX)) y_d = y_q + AW'(1);
                2'd2:    if (x_q != '0)        x_d = x_q - AW'(1);
                default: if (y_q != '0)        y_d = y_q - AW'(1);
              endcase
            end
          end
`ifdef LCD_WIN_MIRROR_EN
          CMD_MIRROR:  mirror_d = ~mirror_q;
`endif
          default: ;
        endcase
        cnt_d   = '0;
        state_d = ST_OUT;
      end
      ST_OUT: begin
        dout_d  = mem_q[pix_addr];
        valid_d = 1'b1;
        cnt_d   = cnt_q + AW'(1);
        if (cnt_q == AW'(NOUT - 1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // busy covers the registered last pixel so it drops together with output_valid
    busy_d = (state_d != ST_IDLE) || valid_d;
  end

  // Control and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      cmd_q    <= '0;
      mode_q   <= MODE_FIT;
      orient_q <= 2'd0;
      mirror_q <= 1'b0;
      x_q      <= AW'(X_C);
      y_q      <= AW'(Y_C);
      dout_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cmd_q    <= cmd_d;
      mode_q   <= mode_d;
      orient_q <= orient_d;
      mirror_q <= mirror_d;
      x_q      <= x_d;
      y_q      <= y_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  // Frame storage, written in raster order during LOAD
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NPIX; k++) mem_q[k] <= '0;
    end else if (mem_we) begin
      mem_q[cnt_q] <= datain;
    end
  end

  assign dataout      = dout_q;
  assign output_valid = valid_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_lcd_window_ctrl.sv
// tb/tb_lcd_window_ctrl.sv - self-checking bench for lcd_window_ctrl
module tb_lcd_window_ctrl;

  localparam int IMG_W = 12;
  localparam int IMG_H = 9;
  localparam int WIN   = 4;
`ifdef LCD_WIN_MIRROR_EN
  localparam int MAXC = 9;
`else
  localparam int MAXC = 8;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] datain = '0;
  logic [3:0] cmd = '0;
  logic       cmd_valid = 1'b0;
  logic [7:0] dataout;
  logic       output_valid;
  logic       busy;

  int total = 0;
  int bad = 0;

  int img [IMG_W*IMG_H];
  int m_mode, m_orient, m_mirror, m_x, m_y;
  int exp_q [$];
  int got [$];
  int run = 0;

  lcd_window_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .datain      (datain),
    .cmd         (cmd),
    .cmd_valid   (cmd_valid),
    .dataout     (dataout),
    .output_valid(output_valid),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // window coordinate shown at display (r,c) under current orient/mirror
  task automatic win_of(input int r, input int c, output int i, output int j);
    int cc;
    cc = m_mirror ? (WIN - 1 - c) : c;
    case (m_orient)
      1: begin i = WIN - 1 - cc; j = r; end
      2: begin i = WIN - 1 - r; j = WIN - 1 - cc; end
      3: begin i = cc; j = WIN - 1 - r; end
      default: begin i = r; j = cc; end
    endcase
  endtask

  task automatic push_frame();
    int i, j, row, col;
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < WIN; c++) begin
        win_of(r, c, i, j);
        if (m_mode == 1) begin row = m_y + i; col = m_x + j; end
        else begin row = 1 + 2 * i; col = 1 + 3 * j; end
        exp_q.push_back(img[row * IMG_W + col]);
      end
  endtask

  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  task automatic model_cmd(input int code);
    int dr, dc, i0, j0, i1, j1;
    case (code)
      1: m_orient = (m_orient + 3) % 4;
      2: m_orient = (m_orient + 1) % 4;
      3: begin m_mode = 1; m_x = 4; m_y = 3; end
      4: m_mode = 0;
      5, 6, 7, 8: begin
        dr = (code == 7) ? -1 : ((code == 8) ? 1 : 0);
        dc = (code == 5) ? 1 : ((code == 6) ? -1 : 0);
        win_of(1, 1, i0, j0);
        win_of(1 + dr, 1 + dc, i1, j1);
        if (m_mode == 1) begin
          m_x = clampi(m_x + j1 - j0, IMG_W - WIN);
          m_y = clampi(m_y + i1 - i0, IMG_H - WIN);
        end
      end
      9: m_mirror = 1 - m_mirror;
      default: ;
    endcase
  endtask

  // compare process: every valid pixel against the model queue
  always @(negedge clk) begin
    if (output_valid) begin
      run++;
      got.push_back(int'(dataout));
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_pixel: got %0d expected none", dataout);
      end else begin
        check("pixel", int'(dataout), exp_q.pop_front());
      end
      check("busy_with_valid", int'(busy), 1);
    end else if (run != 0) begin
      check("burst_len", run, WIN * WIN);
      run = 0;
    end
  end

  task automatic wait_idle();
    bit last_v;
    bit done;
    last_v = output_valid;
    done = 0;
    for (int n = 0; n < 400 && !done; n++) begin
      @(negedge clk);
      if (!busy) done = 1;
      else last_v = output_valid;
    end
    check("idle_reached", int'(done), 1);
    check("fall_together", {last_v, output_valid}, 2'b10);
    check("drain", exp_q.size(), 0);
  endtask

  task automatic do_cmd(input int code);
    got.delete();
    @(negedge clk);
    cmd = 4'(code);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("busy_rise", int'(busy), 1);
    model_cmd(code);
    push_frame();
    wait_idle();
  endtask

  task automatic do_drop(input int code);
    @(negedge clk);
    cmd = 4'(code);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("drop_busy", int'(busy), 0);
    @(negedge clk);
    check("drop_busy2", int'(busy), 0);
  endtask

  task automatic do_load(input bit ramp);
    got.delete();
    for (int k = 0; k < IMG_W * IMG_H; k++) img[k] = ramp ? k : int'($urandom_range(0, 255));
    @(negedge clk);
    cmd = 4'd0;
    cmd_valid = 1'b1;
    for (int k = 0; k < IMG_W * IMG_H; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      datain = 8'(img[k]);
    end
    check("load_busy", int'(busy), 1);
    m_mode = 0; m_orient = 0; m_mirror = 0;
    push_frame();
    wait_idle();
  endtask

  task automatic model_reset();
    for (int k = 0; k < IMG_W * IMG_H; k++) img[k] = 0;
    m_mode = 0; m_orient = 0; m_mirror = 0; m_x = 4; m_y = 3;
    exp_q.delete();
  endtask

  task automatic check_first_row(input string name, input int a, input int b, input int c, input int d);
    check({name, "_n"}, got.size(), 16);
    if (got.size() >= 4) begin
      check({name, "_0"}, got[0], a);
      check({name, "_1"}, got[1], b);
      check({name, "_2"}, got[2], c);
      check({name, "_3"}, got[3], d);
    end
  endtask

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int t1 [16];
    int nv, code;
    t1 = '{13, 16, 19, 22, 37, 40, 43, 46, 61, 64, 67, 70, 85, 88, 91, 94};
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_dataout", int'(dataout), 0);
    check("rst_valid", int'(output_valid), 0);
    check("rst_busy", int'(busy), 0);
    reset = 1'b1;

    // T1 ramp load, fit view
    do_load(1'b1);
    check("t1_n", got.size(), 16);
    for (int k = 0; k < 16 && k < got.size(); k++) check("t1_pix", got[k], t1[k]);

    // T2 zoom, then pan up into the clamp
    do_cmd(3);
    check_first_row("t2_zoom", 40, 41, 42, 43);
    if (got.size() == 16) begin
      check("t2_zoom_4", got[4], 52);
      check("t2_zoom_15", got[15], 79);
    end
    repeat (4) do_cmd(7);
    check_first_row("t2_up", 4, 5, 6, 7);

    // T3 rotations
    do_cmd(3);
    do_cmd(2);
    check_first_row("t3_rotr", 76, 64, 52, 40);
    do_cmd(1);
    do_cmd(1);
    check_first_row("t3_rotl", 43, 55, 67, 79);

    // T4 pan right into the clamp
    do_cmd(2);
    do_cmd(3);
    repeat (5) do_cmd(5);
    check_first_row("t4_right", 44, 45, 46, 47);

    // T5 held command during OUT; then dropped codes
    got.delete();
    @(negedge clk); cmd = 4'd2; cmd_valid = 1'b1;
    @(negedge clk); cmd_valid = 1'b0;
    model_cmd(2);
    push_frame();
    nv = 0;
    for (int n = 0; n < 50 && !output_valid; n++) @(negedge clk);
    check("t5_first_valid", int'(output_valid), 1);
    cmd = 4'd5; cmd_valid = 1'b1;
    model_cmd(5);
    push_frame();
    nv = 1;
    for (int n = 0; n < 50 && nv < 16; n++) begin
      @(negedge clk);
      if (output_valid) nv++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_idle();
    check("t5_total", got.size(), 32);
    do_drop(12);
    do_drop(15);
    if (MAXC == 8) do_drop(9);

    // randomized command mix
    for (int it = 0; it < 40; it++) begin
      code = int'($urandom_range(0, 15));
      if (code == 0 && $urandom_range(0, 3) != 0) code = 3;
      if (code == 0) do_load(1'b0);
      else if (code <= MAXC) do_cmd(code);
      else do_drop(code);
    end

    // T6 reset in the middle of LOAD
    @(negedge clk); cmd = 4'd0; cmd_valid = 1'b1;
    @(negedge clk); cmd_valid = 1'b0;
    repeat (50) begin
      @(negedge clk);
      datain = 8'($urandom_range(0, 255));
    end
    #2 reset = 1'b0;
    #1;
    check("t6_dataout", int'(dataout), 0);
    check("t6_valid", int'(output_valid), 0);
    check("t6_busy", int'(busy), 0);
    repeat (3) begin
      @(negedge clk);
      check("t6_quiet", int'(output_valid | busy), 0);
    end
    model_reset();
    reset = 1'b1;
    do_cmd(3);
    check_first_row("t6_cleared", 0, 0, 0, 0);
    do_load(1'b1);
    check("t6_n", got.size(), 16);
    for (int k = 0; k < 16 && k < got.size(); k++) check("t6_pix", got[k], t1[k]);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
